ysyx_22040632_div_ctrl: RTL

Sequencer between the EXU and the iterative divider (divider-side port set matches the divider modport).
- Accepts RV64M DIV/DIVU/REM/REMU and W variants over a valid/ready request channel.
- Resolves divide-by-zero and signed overflow locally, without using the divider.
- Keeps a one-entry quotient/remainder cache so that a DIV/REM pair on the same operands uses the divider once.
- Handles pipeline flush, and holds the result until the consumer accepts it.

---
 rtl/ysyx_22040632_div_pkg.sv | 21 ++
 rtl/ysyx_22040632_div_special.sv | 58 +++++
 rtl/ysyx_22040632_div_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040632_div_pkg.sv
// Shared types and constants for the divider sequencer.
package ysyx_22040632_div_pkg;

  localparam int DIV_XLEN = 64;

  // Encoding matches the EXU req_op field.
  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } div_state_e;

endpackage

// File: rtl/ysyx_22040632_div_special.sv
// Detects divide-by-zero and signed overflow and produces the
// architecturally defined quotient/remainder, so these cases never
// reach the iterative divider.
module ysyx_22040632_div_special
  import ysyx_22040632_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            w,
  output logic            is_special,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);

  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] dividend_sext;
  logic [XLEN-1:0] min_neg_w;
  logic [XLEN-1:0] min_neg_d;
  logic [XLEN-1:0] minus_one;

  assign dividend_sext = {{(XLEN-32){dividend[31]}}, dividend[31:0]};
  assign min_neg_w     = {{(XLEN-31){1'b1}}, 31'd0};
  assign min_neg_d     = {1'b1, {(XLEN-1){1'b0}}};
  assign minus_one     = '1;

  // W operations only look at the low word of each operand.
  always_comb begin
    if (w) begin
      div_zero = (divisor[31:0] == 32'd0);
      overflow = is_signed && (dividend[31:0] == 32'h8000_0000) &&
                 (divisor[31:0] == 32'hFFFF_FFFF);
    end else begin
      div_zero = (divisor == '0);
      overflow = is_signed && (dividend == min_neg_d) && (divisor == minus_one);
    end
  end

  // Select the fixed result; zero divisor wins (the two never coincide).
  always_comb begin
    is_special = 1'b0;
    q          = '0;
    r          = '0;
    if (div_zero) begin
      is_special = 1'b1;
      q          = '1;
      r          = w ? dividend_sext : dividend;
    end else if (overflow) begin
      is_special = 1'b1;
      q          = w ? min_neg_w : dividend;
      r          = '0;
    end
  end

endmodule

// File: rtl/ysyx_22040632_div_ctrl.sv
// Sequencer between the EXU and the iterative divider. Resolves special
// cases locally, reuses the last quotient/remainder pair through a
// one-entry cache, and holds the result until the consumer takes it.
module ysyx_22040632_div_ctrl
  import ysyx_22040632_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_w,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            div_valid,
  output logic            div_divw,
  output logic            div_signed,
  output logic            div_flush,
  input  logic            div_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  div_state_e      state, state_next;
  div_op_e         req_op_e;
  logic            req_signed;

  div_op_e         op_reg;
  logic            w_reg;
  logic            signed_reg;
  logic [XLEN-1:0] src1_reg;
  logic [XLEN-1:0] src2_reg;
  logic [XLEN-1:0] q_reg, r_reg;

  logic            cache_valid;
  logic            cache_w;
  logic            cache_signed;
  logic [XLEN-1:0] cache_src1, cache_src2;
  logic [XLEN-1:0] cache_q, cache_r;
  logic            cache_hit;

  logic            spec_hit;
  logic [XLEN-1:0] spec_q, spec_r;

  logic            load_req;
  logic            load_res;
  logic            cache_wr;
  logic [XLEN-1:0] q_next, r_next;
  logic [XLEN-1:0] sel_res;

  assign req_op_e   = div_op_e'(req_op);
  assign req_signed = (req_op_e == DIV) || (req_op_e == REM);

  ysyx_22040632_div_special #(
    .XLEN(XLEN)
  ) u_special (
    .dividend   (req_src1),
    .divisor    (req_src2),
    .is_signed  (req_signed),
    .w          (req_w),
    .is_special (spec_hit),
    .q          (spec_q),
    .r          (spec_r)
  );

  assign cache_hit = cache_valid && (cache_src1 == req_src1) &&
                     (cache_src2 == req_src2) && (cache_signed == req_signed) &&
                     (cache_w == req_w);

  assign req_ready    = (state == IDLE) && !flush;
  assign resp_valid   = (state == RESP);
  assign div_valid    = (state == ISSUE) && !flush;
  assign div_flush    = (state == BUSY) && flush;
  assign div_dividend = src1_reg;
  assign div_divisor  = src2_reg;
  assign div_divw     = w_reg;
  assign div_signed   = signed_reg;

  // Result is a pure function of held registers, so it stays stable in RESP.
  assign sel_res   = ((op_reg == REM) || (op_reg == REMU)) ? r_reg : q_reg;
  assign resp_data = w_reg ? {{(XLEN-32){sel_res[31]}}, sel_res[31:0]} : sel_res;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath strobes; flush takes priority in every state.
  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    load_res   = 1'b0;
    cache_wr   = 1'b0;
    q_next     = q_reg;
    r_next     = r_reg;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          load_req = 1'b1;
          if (spec_hit) begin
            load_res   = 1'b1;
            q_next     = spec_q;
            r_next     = spec_r;
            state_next = RESP;
          end else if (cache_hit) begin
            load_res   = 1'b1;
            q_next     = cache_q;
            r_next     = cache_r;
            state_next = RESP;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (flush)          state_next = IDLE;
        else if (div_ready) state_next = BUSY;
      end
      BUSY: begin
        if (flush) begin
          state_next = IDLE;
        end else if (div_out_valid) begin
          load_res   = 1'b1;
          cache_wr   = 1'b1;
          q_next     = div_quotient;
          r_next     = div_remainder;
          state_next = RESP;
        end
      end
      RESP: begin
        if (flush || resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= DIV;
      w_reg      <= 1'b0;
      signed_reg <= 1'b0;
      src1_reg   <= '0;
      src2_reg   <= '0;
      q_reg      <= '0;
      r_reg      <= '0;
    end else begin
      if (load_req) begin
        op_reg     <= req_op_e;
        w_reg      <= req_w;
        signed_reg <= req_signed;
        src1_reg   <= req_src1;
        src2_reg   <= req_src2;
      end
      if (load_res) begin
        q_reg <= q_next;
        r_reg <= r_next;
      end
    end
  end

  // One-entry cache, written only by a completed divider run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid  <= 1'b0;
      cache_w      <= 1'b0;
      cache_signed <= 1'b0;
      cache_src1   <= '0;
      cache_src2   <= '0;
      cache_q      <= '0;
      cache_r      <= '0;
    end else if (cache_wr) begin
      cache_valid  <= 1'b1;
      cache_w      <= w_reg;
      cache_signed <= signed_reg;
      cache_src1   <= src1_reg;
      cache_src2   <= src2_reg;
      cache_q      <= div_quotient;
      cache_r      <= div_remainder;
    end
  end

endmodule
